// File: rtl/mmio_uart_tx_ctrl_pkg.sv
// Shared state encoding, default MMIO addresses and status-word layout
// for the MMIO UART transmit controller.
package mmio_uart_tx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

  localparam logic [31:0] DEF_TX_ADDR     = 32'h1001_0000;
  localparam logic [31:0] DEF_STATUS_ADDR = 32'h1001_0004;

  localparam int unsigned STAT_EMPTY_BIT = 0;
  localparam int unsigned STAT_FULL_BIT  = 1;
  localparam int unsigned STAT_BUSY_BIT  = 2;
  localparam int unsigned STAT_COUNT_LSB = 8;
  localparam int unsigned COUNT_W        = 5;

endpackage

// File: rtl/mmio_uart_tx_ctrl_fifo.sv
// Byte FIFO for the UART transmit path. DEPTH may be 1, in which case it
// degenerates to a single holding register. Caller guards push/pop.
module uart_tx_fifo
  import mmio_uart_tx_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  output logic               full,
  output logic               empty,
  output logic [COUNT_W-1:0] count
);

  localparam int unsigned    PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]  LAST = PW'(DEPTH - 1);

  logic [7:0]         mem_q [DEPTH];
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [COUNT_W-1:0] count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = (tail_q == LAST) ? '0 : tail_q + PW'(1);
    if (pop)  head_d = (head_q == LAST) ? '0 : head_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + COUNT_W'(1);
      2'b01:   count_d = count_q - COUNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the flushed count masks stale entries.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= din;
  end

  assign dout  = mem_q[head_q];
  assign full  = (count_q == COUNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/mmio_uart_tx_ctrl.sv
// MMIO front end feeding a UART transmitter through a byte FIFO.
// Define MMIO_UART_TX_FIFO_EN for a DEPTH-entry FIFO; otherwise one holding register.
module mmio_uart_tx_ctrl
  import mmio_uart_tx_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ACK_TIMEOUT = 4,
  parameter logic [31:0] TX_ADDR     = DEF_TX_ADDR,
  parameter logic [31:0] STATUS_ADDR = DEF_STATUS_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mmio_wr_en,
  input  logic        mmio_rd_en,
  input  logic [31:0] mmio_addr,
  input  logic [31:0] mmio_wdata,
  output logic [31:0] mmio_rdata,
  output logic        mmio_stall,
  input  logic        UART_busy,
  output logic        mmio_uart_tx_start,
  output logic [7:0]  mmio_uart_tx_data
);

`ifdef MMIO_UART_TX_FIFO_EN
  localparam int unsigned FIFO_DEPTH = DEPTH;
`else
  // Single holding register regardless of DEPTH.
  localparam int unsigned FIFO_DEPTH = DEPTH / DEPTH;
`endif

  localparam int unsigned   AW       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);

  tx_state_e          state_q, state_d;
  logic [AW-1:0]      ack_cnt_q, ack_cnt_d;
  logic [7:0]         tx_data_q, tx_data_d;

  logic               tx_sel, st_sel;
  logic               push, pop;
  logic [7:0]         fifo_dout;
  logic               fifo_full, fifo_empty;
  logic [COUNT_W-1:0] fifo_count;
  logic               unused_wdata_hi;

  assign unused_wdata_hi = ^mmio_wdata[31:8];

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (mmio_wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A full FIFO refuses the store even when a pop frees a slot this cycle.
  always_comb begin
    tx_sel     = (mmio_addr == TX_ADDR);
    st_sel     = (mmio_addr == STATUS_ADDR);
    mmio_stall = mmio_wr_en && tx_sel && fifo_full;
    push       = mmio_wr_en && tx_sel && !fifo_full;
    mmio_rdata = '0;
    if (mmio_rd_en && st_sel) begin
      mmio_rdata[STAT_EMPTY_BIT]            = fifo_empty;
      mmio_rdata[STAT_FULL_BIT]             = fifo_full;
      mmio_rdata[STAT_BUSY_BIT]             = (state_q != IDLE);
      mmio_rdata[STAT_COUNT_LSB +: COUNT_W] = fifo_count;
    end
  end

  always_comb begin
    state_d            = state_q;
    ack_cnt_d          = ack_cnt_q;
    tx_data_d          = tx_data_q;
    pop                = 1'b0;
    mmio_uart_tx_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !UART_busy) begin
          pop       = 1'b1;
          tx_data_d = fifo_dout;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        mmio_uart_tx_start = 1'b1;
        ack_cnt_d          = '0;
        state_d            = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (UART_busy)                   state_d   = WAIT_DONE;
        else if (ack_cnt_q == ACK_LAST)  state_d   = IDLE;
        else                             ack_cnt_d = ack_cnt_q + AW'(1);
      end
      WAIT_DONE: begin
        if (!UART_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ack_cnt_q <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ack_cnt_q <= ack_cnt_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign mmio_uart_tx_data = tx_data_q;

endmodule

// File: tb/tb_mmio_uart_tx_ctrl.sv
// Directed self-checking bench for mmio_uart_tx_ctrl; follows the
// MMIO_UART_TX_FIFO_EN build option to pick the effective FIFO depth.
module tb_mmio_uart_tx_ctrl;

  localparam logic [31:0] TX   = 32'h1001_0000;
  localparam logic [31:0] STAT = 32'h1001_0004;
`ifdef MMIO_UART_TX_FIFO_EN
  localparam int unsigned EFF = 8;
`else
  localparam int unsigned EFF = 1;
`endif

  logic        clk;
  logic        reset;
  logic        mmio_wr_en;
  logic        mmio_rd_en;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;
  logic        mmio_stall;
  logic        UART_busy;
  logic        mmio_uart_tx_start;
  logic [7:0]  mmio_uart_tx_data;

  int          checks;
  int          failures;
  int          start_cnt;
  logic [7:0]  start_q[$];

  mmio_uart_tx_ctrl #(
    .DEPTH       (8),
    .ACK_TIMEOUT (4),
    .TX_ADDR     (32'h1001_0000),
    .STATUS_ADDR (32'h1001_0004)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .mmio_wr_en         (mmio_wr_en),
    .mmio_rd_en         (mmio_rd_en),
    .mmio_addr          (mmio_addr),
    .mmio_wdata         (mmio_wdata),
    .mmio_rdata         (mmio_rdata),
    .mmio_stall         (mmio_stall),
    .UART_busy          (UART_busy),
    .mmio_uart_tx_start (mmio_uart_tx_start),
    .mmio_uart_tx_data  (mmio_uart_tx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every launch with the byte presented at that moment.
  initial start_cnt = 0;
  always @(negedge clk) begin
    if (mmio_uart_tx_start === 1'b1) begin
      start_cnt = start_cnt + 1;
      start_q.push_back(mmio_uart_tx_data);
    end
  end

  function automatic logic [31:0] status_exp(int unsigned cnt, logic busy_st);
    logic [31:0] v;
    v       = '0;
    v[0]    = (cnt == 0);
    v[1]    = (cnt == EFF);
    v[2]    = busy_st;
    v[12:8] = cnt[4:0];
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [7:0] b);
    mmio_rd_en = 1'b0;
    mmio_wr_en = 1'b1;
    mmio_addr  = TX;
    mmio_wdata = {24'hA5A5A5, b};
  endtask

  task automatic read_status(output logic [31:0] v);
    mmio_wr_en = 1'b0;
    mmio_rd_en = 1'b1;
    mmio_addr  = STAT;
    #1;
    v          = mmio_rdata;
    mmio_rd_en = 1'b0;
    mmio_addr  = '0;
  endtask

  task automatic push_hold(input logic [7:0] b);
    int n;
    n = 0;
    store(b);
    #1;
    while (mmio_stall === 1'b1 && n < 100) begin
      cyc();
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL push_hold_timeout byte=%02h stall=%0b required=0 within 100 cycles", b, mmio_stall);
    end
    cyc();
    mmio_wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] v;
    int n;
    n = 0;
    read_status(v);
    while (v !== 32'h1 && n < budget) begin
      cyc();
      read_status(v);
      n++;
    end
    checks++;
    if (v !== 32'h1) begin
      failures++;
      $display("FAIL wait_idle status=%08h required=00000001", v);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mmio_uart_tx_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%0b required=0", mmio_uart_tx_start); end
    checks++; if (mmio_uart_tx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%02h required=00", mmio_uart_tx_data); end
    read_status(v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL reset_status got=%08h required=00000001", v); end
    mmio_rd_en = 1'b0; mmio_addr = STAT; #1;
    checks++; if (mmio_rdata !== 32'h0) begin failures++; $display("FAIL rdata_no_rd got=%08h required=00000000", mmio_rdata); end
    mmio_rd_en = 1'b1; mmio_addr = TX; #1;
    checks++; if (mmio_rdata !== 32'h0) begin failures++; $display("FAIL rdata_other_addr got=%08h required=00000000", mmio_rdata); end
    mmio_rd_en = 1'b0; mmio_addr = '0;
    reset = 1'b0;
    cyc();
    read_status(v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL post_reset_status got=%08h required=00000001", v); end
    checks++; if (start_cnt !== 0) begin failures++; $display("FAIL reset_no_start got=%0d required=0", start_cnt); end
  endtask

  task automatic test_single();
    logic [31:0] v;
    int s0;
    s0 = start_cnt;
    UART_busy = 1'b0;
    store(8'h48);
    #1;
    checks++; if (mmio_stall !== 1'b0) begin failures++; $display("FAIL single_stall got=%0b required=0", mmio_stall); end
    cyc();
    mmio_wr_en = 1'b0;
    checks++; if (mmio_uart_tx_start !== 1'b0) begin failures++; $display("FAIL single_early_start got=%0b required=0", mmio_uart_tx_start); end
    read_status(v);
    checks++; if (v !== status_exp(1, 1'b0)) begin failures++; $display("FAIL single_status_queued got=%08h required=%08h", v, status_exp(1, 1'b0)); end
    cyc();
    checks++; if (mmio_uart_tx_start !== 1'b1) begin failures++; $display("FAIL single_start got=%0b required=1", mmio_uart_tx_start); end
    checks++; if (mmio_uart_tx_data !== 8'h48) begin failures++; $display("FAIL single_data got=%02h required=48", mmio_uart_tx_data); end
    read_status(v);
    checks++; if (v !== status_exp(0, 1'b1)) begin failures++; $display("FAIL single_status_launch got=%08h required=%08h", v, status_exp(0, 1'b1)); end
    cyc();
    checks++; if (mmio_uart_tx_start !== 1'b0) begin failures++; $display("FAIL single_start_width got=%0b required=0", mmio_uart_tx_start); end
    UART_busy = 1'b1;
    repeat (10) cyc();
    UART_busy = 1'b0;
    read_status(v);
    checks++; if (v !== status_exp(0, 1'b1)) begin failures++; $display("FAIL single_status_done got=%08h required=%08h", v, status_exp(0, 1'b1)); end
    cyc();
    read_status(v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL single_back_idle got=%08h required=00000001", v); end
    checks++; if (mmio_uart_tx_data !== 8'h48) begin failures++; $display("FAIL single_data_hold got=%02h required=48", mmio_uart_tx_data); end
    checks++; if (start_cnt - s0 !== 1) begin failures++; $display("FAIL single_start_count got=%0d required=1", start_cnt - s0); end
  endtask

  task automatic test_fifo_full();
    logic [31:0] v;
    int s0;
    s0 = start_cnt;
    start_q.delete();
    UART_busy = 1'b1;
    for (int i = 0; i < int'(EFF); i++) begin
      store(8'(8'h30 + i));
      #1;
      checks++; if (mmio_stall !== 1'b0) begin failures++; $display("FAIL full_fill_stall idx=%0d got=%0b required=0", i, mmio_stall); end
      cyc();
    end
    read_status(v);
    checks++; if (v !== status_exp(EFF, 1'b0)) begin failures++; $display("FAIL full_status got=%08h required=%08h", v, status_exp(EFF, 1'b0)); end
    mmio_wr_en = 1'b1; mmio_addr = TX + 32'h8; #1;
    checks++; if (mmio_stall !== 1'b0) begin failures++; $display("FAIL full_other_addr_stall got=%0b required=0", mmio_stall); end
    store(8'(8'h30 + EFF));
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (mmio_stall !== 1'b1) begin failures++; $display("FAIL full_stall cyc=%0d got=%0b required=1", k, mmio_stall); end
      cyc();
    end
    UART_busy = 1'b0;
    #1;
    checks++; if (mmio_stall !== 1'b1) begin failures++; $display("FAIL full_stall_on_pop got=%0b required=1", mmio_stall); end
    cyc();
    checks++; if (mmio_stall !== 1'b0) begin failures++; $display("FAIL full_accept_after_pop got=%0b required=0", mmio_stall); end
    cyc();
    mmio_wr_en = 1'b0;
    for (int i = int'(EFF) + 1; i < 9; i++) push_hold(8'(8'h30 + i));
    wait_idle(400);
    checks++; if (start_cnt - s0 !== 9) begin failures++; $display("FAIL full_start_count got=%0d required=9", start_cnt - s0); end
    for (int i = 0; i < 9 && i < start_q.size(); i++) begin
      checks++; if (start_q[i] !== 8'(8'h30 + i)) begin failures++; $display("FAIL full_order idx=%0d got=%02h required=%02h", i, start_q[i], 8'(8'h30 + i)); end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] v;
    int s0;
    s0 = start_cnt;
    UART_busy = 1'b0;
    store(8'h55);
    cyc();
    mmio_wr_en = 1'b0;
    cyc();
    checks++; if (mmio_uart_tx_start !== 1'b1 || mmio_uart_tx_data !== 8'h55) begin failures++; $display("FAIL to_first_launch start=%0b data=%02h required start=1 data=55", mmio_uart_tx_start, mmio_uart_tx_data); end
    store(8'h66);
    #1;
    checks++; if (mmio_stall !== 1'b0) begin failures++; $display("FAIL to_queue_stall got=%0b required=0", mmio_stall); end
    cyc();
    mmio_wr_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      read_status(v);
      checks++; if (v !== status_exp(1, 1'b1) || mmio_uart_tx_start !== 1'b0) begin failures++; $display("FAIL to_wait_ack cyc=%0d status=%08h start=%0b required status=%08h start=0", k, v, mmio_uart_tx_start, status_exp(1, 1'b1)); end
      cyc();
    end
    read_status(v);
    checks++; if (v !== status_exp(1, 1'b0) || mmio_uart_tx_start !== 1'b0) begin failures++; $display("FAIL to_idle status=%08h start=%0b required status=%08h start=0", v, mmio_uart_tx_start, status_exp(1, 1'b0)); end
    cyc();
    checks++; if (mmio_uart_tx_start !== 1'b1 || mmio_uart_tx_data !== 8'h66) begin failures++; $display("FAIL to_next_launch start=%0b data=%02h required start=1 data=66", mmio_uart_tx_start, mmio_uart_tx_data); end
    cyc();
    UART_busy = 1'b1;
    cyc();
    UART_busy = 1'b0;
    cyc();
    read_status(v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL to_end_idle got=%08h required=00000001", v); end
    checks++; if (start_cnt - s0 !== 2) begin failures++; $display("FAIL to_start_count got=%0d required=2", start_cnt - s0); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int unsigned nq;
    int s1;
    nq = (EFF < 3) ? EFF : 3;
    UART_busy = 1'b0;
    store(8'hA0);
    cyc();
    mmio_wr_en = 1'b0;
    cyc();
    UART_busy = 1'b1;
    cyc();
    cyc();
    for (int i = 0; i < int'(nq); i++) begin
      store(8'(8'hA1 + i));
      #1;
      checks++; if (mmio_stall !== 1'b0) begin failures++; $display("FAIL rm_queue_stall idx=%0d got=%0b required=0", i, mmio_stall); end
      cyc();
    end
    mmio_wr_en = 1'b0;
    read_status(v);
    checks++; if (v !== status_exp(nq, 1'b1)) begin failures++; $display("FAIL rm_wait_done_status got=%08h required=%08h", v, status_exp(nq, 1'b1)); end
    s1 = start_cnt;
    reset = 1'b1;
    read_status(v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL rm_async_flush got=%08h required=00000001", v); end
    checks++; if (mmio_uart_tx_data !== 8'h00) begin failures++; $display("FAIL rm_reset_data got=%02h required=00", mmio_uart_tx_data); end
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    UART_busy = 1'b0;
    repeat (10) cyc();
    read_status(v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL rm_status_after got=%08h required=00000001", v); end
    checks++; if (start_cnt !== s1) begin failures++; $display("FAIL rm_no_start got=%0d required=%0d", start_cnt, s1); end
  endtask

  task automatic test_push_pop();
    logic [31:0] v;
    int unsigned c, exp_cnt;
    logic        stall_seen, stall_exp;
    int s0;
    c = (EFF < 3) ? EFF : 3;
    stall_exp = (c == EFF);
    exp_cnt   = stall_exp ? c - 1 : c;
    s0 = start_cnt;
    start_q.delete();
    UART_busy = 1'b1;
    for (int i = 0; i < int'(c); i++) begin
      store(8'(8'h10 + i));
      cyc();
    end
    mmio_wr_en = 1'b0;
    read_status(v);
    checks++; if (v !== status_exp(c, 1'b0)) begin failures++; $display("FAIL pp_prefill got=%08h required=%08h", v, status_exp(c, 1'b0)); end
    store(8'(8'h10 + c));
    UART_busy = 1'b0;
    #1;
    stall_seen = mmio_stall;
    checks++; if (stall_seen !== stall_exp) begin failures++; $display("FAIL pp_stall got=%0b required=%0b", stall_seen, stall_exp); end
    cyc();
    mmio_wr_en = 1'b0;
    read_status(v);
    checks++; if (v !== status_exp(exp_cnt, 1'b1)) begin failures++; $display("FAIL pp_count got=%08h required=%08h", v, status_exp(exp_cnt, 1'b1)); end
    if (stall_seen === 1'b1) push_hold(8'(8'h10 + c));
    wait_idle(200);
    checks++; if (start_cnt - s0 !== int'(c) + 1) begin failures++; $display("FAIL pp_start_count got=%0d required=%0d", start_cnt - s0, c + 1); end
    for (int i = 0; i <= int'(c) && i < start_q.size(); i++) begin
      checks++; if (start_q[i] !== 8'(8'h10 + i)) begin failures++; $display("FAIL pp_order idx=%0d got=%02h required=%02h", i, start_q[i], 8'(8'h10 + i)); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    mmio_wr_en = 1'b0;
    mmio_rd_en = 1'b0;
    mmio_addr  = '0;
    mmio_wdata = '0;
    UART_busy  = 1'b0;
    test_reset();
    test_single();
    test_fifo_full();
    test_timeout();
    test_reset_mid();
    test_push_pop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx_ctrl.md
MMIO_UART_TX_CTRL -- requirements
Module: mmio_uart_tx_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, TX FIFO entries; power of two, 2..16.
REQ-002 Parameter ACK_TIMEOUT, default 4, cycles to wait for UART_busy rise after a start pulse.
REQ-003 Parameter TX_ADDR, default 32'h1001_0000, MMIO transmit-data address.
REQ-004 Parameter STATUS_ADDR, default 32'h1001_0004, MMIO status address.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 mmio_wr_en  input  1  core MMIO store strobe.
REQ-008 mmio_rd_en  input  1  core MMIO load strobe.
REQ-009 mmio_addr  input  32  MMIO byte address.
REQ-010 mmio_wdata  input  32  store data; only bits [7:0] are used.
REQ-011 mmio_rdata  output  32  load data, combinational.
REQ-012 mmio_stall  output  1  core hold request; store to TX_ADDR not accepted.
REQ-013 UART_busy  input  1  UART transmitter is shifting a frame.
REQ-014 mmio_uart_tx_start  output  1  one-cycle launch pulse to UART.
REQ-015 mmio_uart_tx_data  output  8  byte presented to UART.

Function
REQ-016 Push: mmio_wr_en=1 and mmio_addr==TX_ADDR and count<DEPTH SHALL write mmio_wdata[7:0] at FIFO tail at the clock edge.
REQ-017 A push request with count==DEPTH SHALL assert mmio_stall combinationally that cycle and SHALL NOT be accepted, even if a pop occurs in the same cycle.
REQ-018 mmio_stall SHALL be 0 for every other access, including stores to other addresses.
REQ-019 Status read: mmio_rd_en=1 and mmio_addr==STATUS_ADDR SHALL return bit0=empty, bit1=full, bit2=(state!=IDLE), bits[12:8]=count, all other bits 0.
REQ-020 mmio_rdata SHALL be 0 for any other address, or when mmio_rd_en=0.
REQ-021 FSM states SHALL be IDLE, LAUNCH, WAIT_ACK, and WAIT_DONE.
REQ-022 In IDLE, if FIFO is non-empty and UART_busy=0, the FSM SHALL pop the head into the tx_data register and go to LAUNCH.
REQ-023 A byte pushed into an empty FIFO SHALL be popped no earlier than the following edge; push-to-start latency is 2 cycles minimum.
REQ-024 In LAUNCH, mmio_uart_tx_start SHALL be 1 for exactly that cycle, and the FSM SHALL go to WAIT_ACK with the ack counter cleared.
REQ-025 In WAIT_ACK: if UART_busy=1, go to WAIT_DONE; else when the counter reaches ACK_TIMEOUT-1, go to IDLE (byte counted as sent); else increment the counter.
REQ-026 In WAIT_DONE, UART_busy=0 SHALL return the FSM to IDLE; there is no timeout.
REQ-027 mmio_uart_tx_data SHALL change only on a pop and SHALL hold its value otherwise.
REQ-028 When a push and a pop occur in the same cycle, count SHALL be unchanged; head and tail pointers SHALL wrap modulo DEPTH.
REQ-029 Back-to-back bytes SHALL have at least one IDLE cycle between the fall of UART_busy and the next start pulse.

Reset
REQ-030 While reset=1: state=IDLE, FIFO flushed (pointers and count 0), ack counter 0, mmio_uart_tx_start=0, mmio_uart_tx_data=8'h00.
REQ-031 Reset asserted mid-frame SHALL abandon the byte in flight and all queued bytes; no start pulse SHALL be issued until after release.

Configuration
REQ-032 Macro MMIO_UART_TX_FIFO_EN: when defined, the FIFO has DEPTH entries.
REQ-033 When MMIO_UART_TX_FIFO_EN is undefined, the FIFO SHALL be a single holding register (effective DEPTH=1), with full = count==1 and status bits[12:8] ∈ {0,1}; all other behaviour is unchanged.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding (2-bit), the default TX_ADDR and STATUS_ADDR constants, and the status bit positions.
REQ-035 The FIFO SHALL be a sub-module, uart_tx_fifo (push, pop, data in/out, full, empty, count); the FSM and MMIO decode SHALL stay in the top module.

Verification
REQ-036 Reset, then store 8'h48 to TX_ADDR with UART_busy=0 -> tx_start pulses 2 cycles later with tx_data=8'h48; UART_busy raised 1 cycle later and held 10 cycles -> FSM returns to IDLE 1 cycle after the fall.
REQ-037 Nine stores 8'h30..8'h38 on consecutive cycles with UART_busy held 1 -> stall on the store that would exceed 8 entries until a pop; status reads full=1, count=8; bytes are emitted strictly in order.
REQ-038 Start pulse while UART_busy stays 0 -> return to IDLE after 4 WAIT_ACK cycles; the next byte then launches normally.
REQ-039 Reset asserted during WAIT_DONE with 3 bytes queued -> status reads 0x001 (empty) after release, and no tx_start occurs.
REQ-040 Push and pop in the same cycle with count=3 -> count stays 3; with MMIO_UART_TX_FIFO_EN undefined, the second store stalls until the first byte pops.
